fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program-counter / instruction-fetch stage directly upstream of the control decoder.
//  Holds the PC, addresses the instruction ROM, and presents the 9-bit instruction to control.
//  Takes control's jump request (pc_jmp_en, 4-bit LUT pointer) and redirects through an
//  internal 16-entry jump-target LUT.
//  Runs a start/done handshake with the testbench/top level and counts executed cycles.
// PARAMETERS
//  PC_W      10      PC / ROM address width; LUT entries are PC_W bits wide
//  START_PC  0       PC loaded on each start
//  HALT_OP   9'h1FF  instruction encoding that ends the program
//  CNT_W     16      cycle counter width
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      synchronous, active-low reset
//  start        in   1      level/pulse; sampled in IDLE and DONE
//  instr_in     in   9      ROM data at address pc (ROM read is combinational)
//  pc_jmp_en    in   1      from control: take jump this cycle
//  lut_ptr      in   4      from control: jump-target LUT index
//  lut_wr_en    in   1      LUT write strobe (program load)
//  lut_wr_addr  in   4      LUT write index
//  lut_wr_data  in   PC_W   LUT write value (absolute target PC)
//  pc           out  PC_W   current PC, drives ROM address
//  instr_out    out  9      instruction to control; 9'h000 when not RUN
//  running      out  1      high in RUN
//  done         out  1      high in DONE
//  cycle_count  out  CNT_W  RUN cycles since last start
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, pc=0, done=0, running=0, cycle_count=0,
//   all 16 LUT entries=0. Reset mid-RUN aborts immediately; no partial jump.
//  FSM states IDLE, RUN, DONE; one instruction per clock, no stalls.
//   IDLE: instr_out=9'h000 (cmp; no reg/mem write). start=1 -> pc<=START_PC,
//    cycle_count<=0, next RUN.
//   RUN: instr_out=instr_in; control decodes same cycle.
//    Next-PC priority, highest first:
//     1. instr_in==HALT_OP -> pc held, next DONE (jump ignored).
//     2. pc_jmp_en=1 -> pc<=lut[lut_ptr].
//     3. otherwise pc<=pc+1, modulo 2^PC_W (all-ones wraps to 0; done not set).
//    cycle_count increments each RUN cycle, HALT cycle included.
//    Saturates at all-ones.
//    start ignored in RUN.
//   DONE: done=1, running=0, instr_out=9'h000, pc and cycle_count held.
//    start=1 -> pc<=START_PC, cycle_count<=0, next RUN (done drops the following cycle).
//  running/done are registered state decodes; never both high.
//  LUT is written at posedge when lut_wr_en=1, in any state.
//   Same-cycle write and jump read of one entry: jump uses the OLD value;
//   the new value is visible next cycle.
//  pc_jmp_en/lut_ptr are ignored outside RUN.
//  Jump latency: the target instruction appears on instr_out the cycle after pc_jmp_en.
// TESTING
//  Reset with LUT written, then rst_n=0 one cycle -> pc=0, lut[*]=0, IDLE, done=0, count=0.
//  Straight line: ROM 0..4 = add,add,add,add,HALT; start pulse -> pc 0,1,2,3,4.
//   Then done=1 and cycle_count=5; pc holds 4.
//  Jump: lut[3]=10'd20; pc=2 with pc_jmp_en=1, lut_ptr=3 -> next pc=20.
//   Same cycle also write lut[3]=7 -> still 20; a later jump via 3 -> 7.
//  HALT vs jump: instr_in=9'h1FF with pc_jmp_en=1 -> DONE, pc unchanged.
//  Wrap: PC_W=4, no HALT, run from 14 -> pc 14,15,0,1; done stays 0.
//  Restart/abort: in DONE assert start -> pc=START_PC, count=0, running next cycle.
//   rst_n=0 mid-RUN -> IDLE next edge, instr_out=9'h000.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC/instruction-fetch stage with start/done handshake and jump LUT
// Fetch runs one instruction per clock in RUN; jumps resolve through a 16-entry absolute-target LUT.
module fetch_unit #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] START_PC = '0,
  parameter logic [8:0]      HALT_OP  = 9'h1FF,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [8:0]       instr_in,
  input  logic             pc_jmp_en,
  input  logic [3:0]       lut_ptr,
  input  logic             lut_wr_en,
  input  logic [3:0]       lut_wr_addr,
  input  logic [PC_W-1:0]  lut_wr_data,
  output logic [PC_W-1:0]  pc,
  output logic [8:0]       instr_out,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  lut_q [16];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = START_PC;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        // HALT outranks a jump requested in the same cycle
        if (instr_in == HALT_OP) begin
          state_d = S_DONE;
        end else if (pc_jmp_en) begin
          pc_d = lut_q[lut_ptr];
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < 16; i++) lut_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      // a jump reading this entry in the same cycle still sees the old target
      if (lut_wr_en) lut_q[lut_wr_addr] <= lut_wr_data;
    end
  end

  assign pc          = pc_q;
  assign cycle_count = cnt_q;
  assign running     = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign instr_out   = (state_q == S_RUN) ? instr_in : 9'h000;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
// Cycle model plus directed runs: straight line, jumps, HALT priority, restart, abort, PC wrap.
module tb_fetch_unit;

  localparam logic [8:0] ADD  = 9'h010;
  localparam logic [8:0] HALT = 9'h1FF;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [8:0]  instr_in;
  logic        pc_jmp_en;
  logic [3:0]  lut_ptr;
  logic        lut_wr_en;
  logic [3:0]  lut_wr_addr;
  logic [9:0]  lut_wr_data;
  logic [9:0]  pc;
  logic [8:0]  instr_out;
  logic        running, done;
  logic [15:0] cycle_count;

  logic        start_w;
  logic [3:0]  pc_w;
  logic [8:0]  instr_out_w;
  logic        running_w, done_w;
  logic [3:0]  cnt_w;

  logic [8:0] rom [0:1023];
  assign instr_in = rom[pc];

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .instr_in(instr_in),
    .pc_jmp_en(pc_jmp_en), .lut_ptr(lut_ptr), .lut_wr_en(lut_wr_en),
    .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data), .pc(pc),
    .instr_out(instr_out), .running(running), .done(done), .cycle_count(cycle_count)
  );

  fetch_unit #(.PC_W(4), .START_PC(4'd14), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .instr_in(ADD),
    .pc_jmp_en(1'b0), .lut_ptr(4'd0), .lut_wr_en(1'b0),
    .lut_wr_addr(4'd0), .lut_wr_data(4'd0), .pc(pc_w),
    .instr_out(instr_out_w), .running(running_w), .done(done_w), .cycle_count(cnt_w)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: 0=idle, 1=run, 2=done; targets held as plain integers
  int m_state, m_pc, m_cnt;
  int m_lut [16];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state <= 0;
      m_pc    <= 0;
      m_cnt   <= 0;
      for (int i = 0; i < 16; i++) m_lut[i] <= 0;
    end else begin
      if (lut_wr_en) m_lut[lut_wr_addr] <= int'(lut_wr_data);
      if (m_state != 1) begin
        if (start) begin
          m_state <= 1;
          m_pc    <= 0;
          m_cnt   <= 0;
        end
      end else begin
        m_cnt <= (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        if (rom[m_pc] == HALT)  m_state <= 2;
        else if (pc_jmp_en)     m_pc <= m_lut[lut_ptr];
        else                    m_pc <= (m_pc + 1) % 1024;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_pc", int'(pc), m_pc);
      chk("model_instr_out", int'(instr_out), (m_state == 1) ? int'(rom[m_pc]) : 0);
      chk("model_running", int'(running), int'(m_state == 1));
      chk("model_done", int'(done), int'(m_state == 2));
      chk("model_cycle_count", int'(cycle_count), m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = ADD;
    rom[4]  = HALT;
    rom[7]  = HALT;
    rst_n = 1'b0; start = 1'b0; start_w = 1'b0;
    pc_jmp_en = 1'b0; lut_ptr = 4'd0;
    lut_wr_en = 1'b0; lut_wr_addr = 4'd0; lut_wr_data = 10'd0;
    step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;

    // fill an entry, then reset must clear it
    lut_wr_en = 1'b1; lut_wr_addr = 4'd5; lut_wr_data = 10'd123;
    step();
    lut_wr_en = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_pc", int'(pc), 0);
    chk("rst_count", int'(cycle_count), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_running", int'(running), 0);
    chk("idle_instr_out", int'(instr_out), 0);

    lut_wr_en = 1'b1; lut_wr_addr = 4'd3; lut_wr_data = 10'd20;
    step();
    lut_wr_en = 1'b0;

    // straight line 0..4 with HALT at 4; start mid-run is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("line_pc", int'(pc), i);
      start = (i == 2);
      step();
    end
    start = 1'b0;
    chk("line_done", int'(done), 1);
    chk("line_count", int'(cycle_count), 5);
    chk("line_pc_hold", int'(pc), 4);
    chk("line_instr_out", int'(instr_out), 0);
    step();
    chk("done_hold_pc", int'(pc), 4);
    chk("done_hold_count", int'(cycle_count), 5);

    // jump via lut[3]=20 while rewriting lut[3]=7 in the same cycle
    start = 1'b1;
    step();
    start = 1'b0;
    chk("jmp_pc0", int'(pc), 0);
    step();
    step();
    chk("jmp_pc2", int'(pc), 2);
    pc_jmp_en = 1'b1; lut_ptr = 4'd3;
    lut_wr_en = 1'b1; lut_wr_addr = 4'd3; lut_wr_data = 10'd7;
    step();
    pc_jmp_en = 1'b0; lut_wr_en = 1'b0;
    chk("jmp_old_target", int'(pc), 20);
    chk("jmp_target_instr", int'(instr_out), int'(ADD));
    pc_jmp_en = 1'b1; lut_ptr = 4'd3;
    step();
    pc_jmp_en = 1'b0;
    chk("jmp_new_target", int'(pc), 7);
    step();
    chk("jmp_done", int'(done), 1);
    chk("jmp_count", int'(cycle_count), 5);

    // restart from DONE, jump through cleared entry, then HALT beats a jump
    start = 1'b1;
    chk("restart_still_done", int'(done), 1);
    step();
    start = 1'b0;
    chk("restart_pc", int'(pc), 0);
    chk("restart_count", int'(cycle_count), 0);
    chk("restart_running", int'(running), 1);
    chk("restart_done", int'(done), 0);
    pc_jmp_en = 1'b1; lut_ptr = 4'd5;
    step();
    pc_jmp_en = 1'b0;
    chk("cleared_lut_target", int'(pc), 0);
    for (int i = 0; i < 4; i++) step();
    chk("halt_pc", int'(pc), 4);
    chk("halt_instr_out", int'(instr_out), int'(HALT));
    pc_jmp_en = 1'b1; lut_ptr = 4'd3;
    step();
    pc_jmp_en = 1'b0;
    chk("halt_vs_jmp_done", int'(done), 1);
    chk("halt_vs_jmp_pc", int'(pc), 4);
    chk("halt_vs_jmp_count", int'(cycle_count), 6);

    // abort mid-run
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_running", int'(running), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_instr_out", int'(instr_out), 0);
    chk("abort_pc", int'(pc), 0);
    chk("abort_count", int'(cycle_count), 0);

    // 4-bit PC wrap and 4-bit counter saturation
    start_w = 1'b1;
    step();
    start_w = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_pc", int'(pc_w), (14 + i) % 16);
      chk("wrap_done", int'(done_w), 0);
      step();
    end
    chk("wrap_count", int'(cnt_w), 4);
    for (int i = 0; i < 14; i++) step();
    chk("sat_count", int'(cnt_w), 15);
    chk("sat_running", int'(running_w), 1);
    chk("sat_done", int'(done_w), 0);
    chk("sat_instr_out", int'(instr_out_w), int'(ADD));

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
